// File: rtl/rs485_hdx_fifo_pkg.sv
// rs485_hdx_fifo_pkg: register map, status/control bit positions, FSM encodings and frame builder
package rs485_hdx_fifo_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STAT   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_TIMING = 2'd3;

    localparam int ST_RXOVR = 3;
    localparam int ST_FERR  = 4;
    localparam int ST_TXOVF = 5;
    localparam int ST_PERR  = 6;

    localparam int CT_RXIE  = 16;
    localparam int CT_TXIE  = 17;
    localparam int CT_ERRIE = 18;

    typedef enum logic [1:0] {DE_IDLE, DE_PRE, DE_SEND, DE_POST} de_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

    // Frame bits in send order from bit 0: start, data LSB first, parity (or a spare stop), stop
    function automatic logic [10:0] tx_frame(input logic [7:0] d, input logic par_en);
        return {1'b1, par_en ? ^d : 1'b1, d, 1'b0};
    endfunction

endpackage

// File: rtl/rs485_hdx_fifo_sync_fifo.sv
// rs485_sync_fifo: single-clock FIFO; push when full and pop when empty are ignored
module rs485_sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int CW = AW + 1;

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count == CW'(2**AW);
    assign empty   = count == '0;
    assign rdata   = mem[rptr];

    // Storage array, no reset needed
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Pointers and occupancy; push and pop in one cycle both take effect
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(do_push);
            rptr  <= rptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/rs485_hdx_fifo.sv
// rs485_hdx_fifo: half-duplex RS485 controller with FIFOs, DE sequencing and register port; RS485_PARITY_EN adds even parity
module rs485_hdx_fifo
    import rs485_hdx_fifo_pkg::*;
#(
    parameter int          FIFO_AW  = 4,
    parameter logic [15:0] DIV_RST  = 16'd26,
    parameter logic [7:0]  PRE_RST  = 8'd1,
    parameter logic [7:0]  POST_RST = 8'd2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        rs485_tx_o,
    input  logic        rs485_rx_i,
    output logic        rs485_de_o,
    input  logic [31:0] addr_32b_i,
    input  logic        wren_i,
    input  logic        rden_i,
    input  logic [31:0] din_32b_i,
    output logic [31:0] dout_32b_o,
    output logic        dout_32b_valid_o,
    output logic        interrupt_o
);

`ifdef RS485_PARITY_EN
    localparam int   NB     = 11;
    localparam logic PAR_EN = 1'b1;
`else
    localparam int   NB     = 10;
    localparam logic PAR_EN = 1'b0;
`endif

    logic [15:0]      div, baud_cnt;
    logic             tick, bit_end;
    logic             rx_ie, tx_ie, err_ie;
    logic [7:0]       pre, post;
    logic             rxovr, ferr, txovf, perr;
    logic             wr_data, wr_stat, wr_ctrl, wr_timing, rd_data;
    logic             tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0]       tx_rdata, rx_rdata;
    logic [FIFO_AW:0] tx_count, rx_count;
    logic             tx_load, tx_idle;
    de_state_t        de_st;
    logic [3:0]       tcnt;
    logic [7:0]       bcnt;
    logic [10:0]      tx_sr;
    rx_state_t        rx_st;
    logic             rx_meta, rx_sync, rx_par;
    logic [3:0]       rcnt;
    logic [2:0]       rbit;
    logic [7:0]       rx_sr;
    logic             rx_done, par_bad, rx_push, set_ferr, set_perr, set_rxovr;
    logic [31:0]      stat, rd_mux;
    logic             unused_ok;

    assign wr_data   = wren_i && addr_32b_i[3:2] == REG_DATA;
    assign wr_stat   = wren_i && addr_32b_i[3:2] == REG_STAT;
    assign wr_ctrl   = wren_i && addr_32b_i[3:2] == REG_CTRL;
    assign wr_timing = wren_i && addr_32b_i[3:2] == REG_TIMING;
    assign rd_data   = rden_i && addr_32b_i[3:2] == REG_DATA;
    assign unused_ok = ^{addr_32b_i[31:4], addr_32b_i[1:0], din_32b_i[31:19], tx_count};

    rs485_sync_fifo #(.W(8), .AW(FIFO_AW)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push    (wr_data),
        .wdata   (din_32b_i[7:0]),
        .pop     (tx_load),
        .rdata   (tx_rdata),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    rs485_sync_fifo #(.W(8), .AW(FIFO_AW)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push    (rx_push),
        .wdata   (rx_sr),
        .pop     (rd_data),
        .rdata   (rx_rdata),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

    assign tick    = baud_cnt == 16'd0;
    assign bit_end = tick && tcnt == 4'd15;
    assign tx_idle = de_st == DE_IDLE && tx_empty;
    // A frame starts when the lead expires, straight from IDLE with no lead, or chained from SEND/POST
    assign tx_load = !tx_empty && ((de_st == DE_IDLE && pre == 8'd0)
                  || (de_st == DE_PRE && bit_end && {1'b0, bcnt} + 9'd1 >= {1'b0, pre})
                  || (de_st == DE_SEND && bit_end && bcnt == 8'(NB - 1))
                  || de_st == DE_POST);

    assign rx_done   = !rs485_de_o && rx_st == RX_STOP && tick && rcnt == 4'd15;
    assign par_bad   = PAR_EN && (rx_par != ^rx_sr);
    assign set_ferr  = rx_done && !rx_sync;
    assign set_perr  = rx_done && rx_sync && par_bad;
    assign set_rxovr = rx_done && rx_sync && !par_bad && rx_full;
    assign rx_push   = rx_done && rx_sync && !par_bad && !rx_full;

    assign stat = {16'd0, 8'(rx_count), 1'b0, perr, txovf, ferr, rxovr, tx_idle, tx_full, !rx_empty};
    assign interrupt_o = (rx_ie && !rx_empty) || (tx_ie && tx_idle) || (err_ie && (rxovr || ferr || txovf || perr));

    // Read data selection for the registered read port
    always_comb begin
        rd_mux = addr_32b_i[3:2] == REG_DATA ? (rx_empty ? 32'd0 : {24'd0, rx_rdata})
               : addr_32b_i[3:2] == REG_STAT ? stat
               : addr_32b_i[3:2] == REG_CTRL ? {13'd0, err_ie, tx_ie, rx_ie, div}
               : {16'd0, post, pre};
    end

    // Configuration, sticky flags, baud counter and registered read port
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div              <= DIV_RST;
            baud_cnt         <= DIV_RST;
            {err_ie, tx_ie, rx_ie} <= 3'b000;
            pre              <= PRE_RST;
            post             <= POST_RST;
            {rxovr, ferr, txovf, perr} <= 4'b0000;
            dout_32b_o       <= 32'd0;
            dout_32b_valid_o <= 1'b0;
        end else begin
            baud_cnt <= wr_ctrl ? din_32b_i[15:0] : tick ? div : baud_cnt - 16'd1;
            if (wr_ctrl) {err_ie, tx_ie, rx_ie, div} <= {din_32b_i[CT_ERRIE], din_32b_i[CT_TXIE], din_32b_i[CT_RXIE], din_32b_i[15:0]};
            if (wr_timing) {post, pre} <= din_32b_i[15:0];
            rxovr <= set_rxovr || (rxovr && !(wr_stat && din_32b_i[ST_RXOVR]));
            ferr  <= set_ferr || (ferr && !(wr_stat && din_32b_i[ST_FERR]));
            txovf <= (wr_data && tx_full) || (txovf && !(wr_stat && din_32b_i[ST_TXOVF]));
            perr  <= set_perr || (perr && !(wr_stat && din_32b_i[ST_PERR]));
            dout_32b_o       <= rden_i ? rd_mux : 32'd0;
            dout_32b_valid_o <= rden_i;
        end
    end

    // DE sequencer and TX shifter: lead, frames back to back, lag, all in 16-tick bit times
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            de_st      <= DE_IDLE;
            rs485_de_o <= 1'b0;
            rs485_tx_o <= 1'b1;
            tcnt       <= 4'd0;
            bcnt       <= 8'd0;
            tx_sr      <= '1;
        end else begin
            if (tick) tcnt <= tcnt + 4'd1;
            if (tx_load) begin
                de_st      <= DE_SEND;
                rs485_de_o <= 1'b1;
                rs485_tx_o <= 1'b0;
                tx_sr      <= tx_frame(tx_rdata, PAR_EN);
                tcnt       <= 4'd0;
                bcnt       <= 8'd0;
            end else begin
                case (de_st)
                    DE_IDLE: if (!tx_empty) begin
                        de_st      <= DE_PRE;
                        rs485_de_o <= 1'b1;
                        tcnt       <= 4'd0;
                        bcnt       <= 8'd0;
                    end
                    DE_PRE: if (bit_end) bcnt <= bcnt + 8'd1;
                    DE_SEND: if (bit_end) begin
                        if (bcnt == 8'(NB - 1)) begin
                            de_st      <= post == 8'd0 ? DE_IDLE : DE_POST;
                            rs485_de_o <= post != 8'd0;
                            bcnt       <= 8'd0;
                        end else begin
                            bcnt       <= bcnt + 8'd1;
                            rs485_tx_o <= tx_sr[1];
                            tx_sr      <= {1'b1, tx_sr[10:1]};
                        end
                    end
                    DE_POST: if (bit_end) begin
                        if ({1'b0, bcnt} + 9'd1 >= {1'b0, post}) begin
                            de_st      <= DE_IDLE;
                            rs485_de_o <= 1'b0;
                        end else begin
                            bcnt <= bcnt + 8'd1;
                        end
                    end
                    default: de_st <= DE_IDLE;
                endcase
            end
        end
    end

    // RX synchroniser and shifter; held idle while driving so our own echo is dropped
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_st   <= RX_IDLE;
            rcnt    <= 4'd0;
            rbit    <= 3'd0;
            rx_sr   <= 8'd0;
            rx_par  <= 1'b0;
        end else begin
            rx_meta <= rs485_rx_i;
            rx_sync <= rx_meta;
            if (tick) rcnt <= rcnt + 4'd1;
            if (rs485_de_o) begin
                rx_st <= RX_IDLE;
            end else begin
                case (rx_st)
                    RX_IDLE: if (!rx_sync) begin
                        rx_st <= RX_START;
                        rcnt  <= 4'd0;
                    end
                    RX_START: if (tick && rcnt == 4'd7) begin
                        rx_st <= rx_sync ? RX_IDLE : RX_DATA;
                        rcnt  <= 4'd0;
                        rbit  <= 3'd0;
                    end
                    RX_DATA: if (tick && rcnt == 4'd15) begin
                        rx_sr <= {rx_sync, rx_sr[7:1]};
                        rbit  <= rbit + 3'd1;
                        if (rbit == 3'd7) rx_st <= PAR_EN ? RX_PAR : RX_STOP;
                    end
                    RX_PAR: if (tick && rcnt == 4'd15) begin
                        rx_par <= rx_sync;
                        rx_st  <= RX_STOP;
                    end
                    RX_STOP: if (tick && rcnt == 4'd15) rx_st <= RX_IDLE;
                    default: rx_st <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rs485_hdx_fifo.sv
// tb_rs485_hdx_fifo: randomized frames checked against a queue/timing model of the controller
module tb_rs485_hdx_fifo;

`ifdef RS485_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int BT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx, de, rx, valid, irq;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        wren = 1'b0;
    logic        rden = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          t_rise = 0;

    assign rx = loop ? tx : rx_drv;

    rs485_hdx_fifo dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .rs485_tx_o       (tx),
        .rs485_rx_i       (rx),
        .rs485_de_o       (de),
        .addr_32b_i       (addr),
        .wren_i           (wren),
        .rden_i           (rden),
        .din_32b_i        (din),
        .dout_32b_o       (dout),
        .dout_32b_valid_o (valid),
        .interrupt_o      (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge de) t_rise = cyc;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        addr = {28'd0, a};
        din  = d;
        wren = 1'b1;
        @(negedge clk);
        wren = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] a, output logic [31:0] d);
        addr = {28'd0, a};
        rden = 1'b1;
        @(negedge clk);
        rden = 1'b0;
        check({tag, "_valid"}, valid, 1'b1);
        d = dout;
    endtask

    function automatic logic [31:0] stat_exp(input int cnt, input logic txfull, input logic txidle,
                                             input logic ovr, input logic fe, input logic tovf);
        return {16'd0, 8'(cnt), 1'b0, 1'b0, tovf, fe, ovr, txidle, txfull, cnt != 0};
    endfunction

    // Observe the line and compare every frame and every DE edge against the expected timing
    task automatic tx_frames(input logic [7:0] q[$], input int pre, input int post);
        int n, ts, tprev;
        logic [7:0] b;
        n = 0;
        while (!de && n < 200) begin @(negedge clk); n++; end
        check("de_rise", de, 1'b1);
        tprev = t_rise;
        for (int k = 0; k < q.size(); k++) begin
            n = 0;
            while (tx && n < 5000) begin @(negedge clk); n++; end
            check("start_seen", tx, 1'b0);
            ts = cyc;
            if (k == 0) check("de_lead", ts - tprev, BT * pre);
            else check("frame_gap", ts - tprev, BT * NB);
            repeat (8) @(negedge clk);
            check("start_bit", tx, 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (BT) @(negedge clk);
                b[i] = tx;
            end
            check("tx_byte", b, q[k]);
`ifdef RS485_PARITY_EN
            repeat (BT) @(negedge clk);
            check("tx_par", tx, ^b);
`endif
            repeat (BT) @(negedge clk);
            check("stop_bit", tx, 1'b1);
            check("de_held", de, 1'b1);
            tprev = ts;
        end
        n = 0;
        while (de && n < 5000) begin @(negedge clk); n++; end
        check("de_fall", de, 1'b0);
        check("de_lag", cyc - tprev, BT * NB + BT * post);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        repeat (BT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (BT) @(negedge clk);
        end
`ifdef RS485_PARITY_EN
        rx_drv = ^b;
        repeat (BT) @(negedge clk);
`endif
        rx_drv = stop;
        repeat (BT) @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  q[$];
        logic [7:0]  mq[$];
        logic        ovr;
        int          pre, post, nb;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_de", de, 1'b0);
        check("rst_dout", dout, 32'd0);
        check("rst_valid", valid, 1'b0);
        check("rst_irq", irq, 1'b0);
        rd("rst_stat", 4'h4, r);   check("rst_stat", r, 32'h4);
        rd("rst_ctrl", 4'h8, r);   check("rst_ctrl", r, 32'd26);
        rd("rst_timing", 4'hC, r); check("rst_timing", r, 32'h0201);

        // Single frame with default guards and the txdone interrupt
        wr(4'h8, 32'h0002_0000);
        check("txdone_irq_idle", irq, 1'b1);
        q = {8'hA5};
        wr(4'h0, 32'hA5);
        tx_frames(q, 1, 2);
        check("txdone_irq", irq, 1'b1);
        rd("t1_stat", 4'h4, r); check("t1_stat", r, 32'h4);

        // Random bursts with random guards, line looped back to prove echo suppression
        loop = 1'b1;
        for (int round = 0; round < 4; round++) begin
            pre  = (round == 0) ? 1 : $urandom_range(0, 3);
            post = (round == 0) ? 2 : $urandom_range(0, 3);
            nb   = (round == 0) ? 3 : $urandom_range(1, 3);
            wr(4'hC, {16'd0, 8'(post), 8'(pre)});
            q = {};
            for (int i = 0; i < nb; i++) q.push_back(8'($urandom));
            foreach (q[i]) wr(4'h0, {24'd0, q[i]});
            tx_frames(q, pre, post);
        end
        loop = 1'b0;
        repeat (4) @(negedge clk);
        rd("echo_stat", 4'h4, r); check("echo_stat", r, 32'h4);
        wr(4'hC, 32'h0201);

        // Receive path, single known byte then random bytes through the model queue
        wr(4'h8, 32'h0001_0000);
        check("rx_irq_off", irq, 1'b0);
        send_rx(8'h3C, 1'b1);
        rd("t3_stat", 4'h4, r); check("t3_stat", r, stat_exp(1, 0, 1, 0, 0, 0));
        check("rx_irq", irq, 1'b1);
        rd("t3_data", 4'h0, r); check("t3_data", r, 32'h3C);
        @(negedge clk);
        check("valid_pulse", valid, 1'b0);
        rd("t3_empty", 4'h0, r); check("t3_empty", r, 32'h0);
        check("rx_irq_clr", irq, 1'b0);

        mq = {};
        for (int i = 0; i < 4; i++) begin
            mq.push_back(8'($urandom));
            send_rx(mq[$], 1'b1);
        end
        rd("rnd_stat", 4'h4, r); check("rnd_stat", r, stat_exp(mq.size(), 0, 1, 0, 0, 0));
        while (mq.size() > 0) begin
            rd("rnd_data", 4'h0, r); check("rnd_data", r, {24'd0, mq.pop_front()});
        end

        // Framing error: byte dropped, flag sticky until write-one-to-clear
        wr(4'h8, 32'h0004_0000);
        send_rx(8'($urandom), 1'b0);
        rd("ferr_stat", 4'h4, r); check("ferr_stat", r, stat_exp(0, 0, 1, 0, 1, 0));
        check("err_irq", irq, 1'b1);
        wr(4'h4, 32'h10);
        rd("ferr_clr", 4'h4, r); check("ferr_clr", r, 32'h4);
        check("err_irq_clr", irq, 1'b0);

        // Overflow: 17 bytes into a 16-deep FIFO
        ovr = 1'b0;
        for (int i = 0; i < 17; i++) begin
            r = $urandom;
            send_rx(r[7:0], 1'b1);
            if (mq.size() < 16) mq.push_back(r[7:0]);
            else ovr = 1'b1;
        end
        rd("ovr_stat", 4'h4, r); check("ovr_stat", r, stat_exp(mq.size(), 0, 1, ovr, 0, 0));
        while (mq.size() > 0) begin
            rd("ovr_data", 4'h0, r); check("ovr_data", r, {24'd0, mq.pop_front()});
        end
        wr(4'h4, 32'h08);
        rd("ovr_clr", 4'h4, r); check("ovr_clr", r, 32'h4);

        // One-cycle glitch must not produce a byte
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        rd("glitch_stat", 4'h4, r); check("glitch_stat", r, 32'h4);

        // TX overflow under a long lead, then reset in the middle of a frame
        wr(4'hC, 32'h02FF);
        wr(4'h8, 32'h0);
        wr(4'h0, 32'h00);
        for (int i = 0; i < 16; i++) wr(4'h0, 32'($urandom_range(0, 255)));
        rd("txovf_stat", 4'h4, r); check("txovf_stat", r, stat_exp(0, 1, 0, 0, 0, 1));
        wr(4'hC, 32'h0201);
        for (int n = 0; n < 200 && tx; n++) @(negedge clk);
        check("t6_start", tx, 1'b0);
        repeat (40) @(negedge clk);
        check("t6_de_before", de, 1'b1);
        check("t6_tx_before", tx, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_tx", tx, 1'b1);
        check("async_de", de, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd("t6_stat", 4'h4, r);   check("t6_stat", r, 32'h4);
        rd("t6_ctrl", 4'h8, r);   check("t6_ctrl", r, 32'd26);
        rd("t6_timing", 4'hC, r); check("t6_timing", r, 32'h0201);
        check("t6_irq", irq, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
